// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared types and constants for the CPU pipeline stages.
//   word_t             : 32-bit machine word (instructions and addresses).
//   if_id_t            : contents of the IF/ID pipeline register
//                        (instr, pc, pc4, valid).
//   NOP_INSTR_DEFAULT  : default instruction word used for bubbles.
//   RESET_PC_DEFAULT   : default program counter after reset.
//   INSTR_BYTES        : byte distance between consecutive instructions.
//   alignWord()        : clears the two byte-offset bits of an address.
// -----------------------------------------------------------------------------
package cpu_pkg;

   typedef logic [31:0] word_t;

   typedef struct packed {
      word_t instr;
      word_t pc;
      word_t pc4;
      logic  valid;
   } if_id_t;

   localparam word_t NOP_INSTR_DEFAULT = 32'h0000_0000;
   localparam word_t RESET_PC_DEFAULT  = 32'h0000_0000;
   localparam word_t INSTR_BYTES       = 32'd4;
   localparam word_t WORD_ALIGN_MASK   = 32'hFFFF_FFFC;

   // Instructions are word aligned, so any address that becomes a PC has its
   // byte-offset bits cleared here rather than trusting the producer.
   function automatic word_t alignWord(input word_t addr);
      return addr & WORD_ALIGN_MASK;
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register with hold and flush controls.
//   clk      : clock, rising-edge active
//   rst_n    : asynchronous active-low reset
//   hold_i   : keep the current contents (hazard stall)
//   flush_i  : replace the instruction with a bubble; pc/pc4 are kept
//   d_i      : fetch packet from the IF stage
//   q_o      : registered packet presented to ID
// Flush wins over hold so a redirect always kills the wrong-path instruction.
// -----------------------------------------------------------------------------
module if_id_reg
   import cpu_pkg::*;
#(
   parameter word_t NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   hold_i,
   input  logic   flush_i,
   input  if_id_t d_i,
   output if_id_t q_o
);

   if_id_t ifid_q;
   if_id_t ifid_d;

   // Next-state selection: a flush turns the slot into a bubble while leaving
   // the pc fields alone, a hold recirculates everything, otherwise load the
   // new fetch packet.
   always_comb begin
      ifid_d = ifid_q;
      if (flush_i) begin
         ifid_d.instr = NOP_INSTR;
         ifid_d.valid = 1'b0;
      end else if (!hold_i) begin
         ifid_d = d_i;
      end
   end

   // The register itself; reset leaves a bubble with cleared pc fields.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ifid_q <= '{instr: NOP_INSTR, pc: '0, pc4: '0, valid: 1'b0};
      end else begin
         ifid_q <= ifid_d;
      end
   end

   assign q_o = ifid_q;

endmodule

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Instruction fetch stage: owns the PC register and next-PC mux and feeds the
// IF/ID register (if_id_reg).
//   Parameters : RESET_PC (PC after reset), NOP_INSTR (bubble instruction)
//   clk, rst_n : clock and asynchronous active-low reset
//   stall      : freeze PC and IF/ID
//   redirect   : taken branch/jump from ID, overrides stall, flushes IF/ID
//   redirect_pc: redirect target (byte-offset bits ignored)
//   imem_addr  : fetch address, equal to the PC register
//   imem_instr : instruction returned combinationally for imem_addr
//   id_instr, id_pc, id_pc4, id_valid : IF/ID register outputs
// Optional build macro IF_PERF_CNT_EN adds perf_fetch, perf_stall and
// perf_flush, free-running 32-bit event counters cleared by reset.
// -----------------------------------------------------------------------------
module if_stage
   import cpu_pkg::*;
#(
   parameter word_t RESET_PC  = RESET_PC_DEFAULT,
   parameter word_t NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc4,
   output logic        id_valid
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetch,
   output logic [31:0] perf_stall,
   output logic [31:0] perf_flush
`endif
);

   word_t  pc_q;
   word_t  pc_d;
   word_t  pcPlus4;
   if_id_t fetchPacket;
   if_id_t ifidOut;

   // Sequential fetch address; the add wraps naturally at 2^32.
   assign pcPlus4 = pc_q + INSTR_BYTES;

   // Next-PC mux: redirect beats stall, stall holds, otherwise step by one
   // instruction.
   always_comb begin
      pc_d = pc_q;
      if (redirect) begin
         pc_d = alignWord(redirect_pc);
      end else if (!stall) begin
         pc_d = pcPlus4;
      end
   end

   // PC register; the reset value is aligned as well so the low bits stay 0
   // even for an odd RESET_PC override.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= alignWord(RESET_PC);
      end else begin
         pc_q <= pc_d;
      end
   end

   assign imem_addr = pc_q;

   // The memory answers in the same cycle, so the packet for the current PC is
   // complete and can be captured by IF/ID on the next edge.
   assign fetchPacket = '{instr: imem_instr, pc: pc_q, pc4: pcPlus4, valid: 1'b1};

   if_id_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .hold_i  (stall),
      .flush_i (redirect),
      .d_i     (fetchPacket),
      .q_o     (ifidOut)
   );

   assign id_instr = ifidOut.instr;
   assign id_pc    = ifidOut.pc;
   assign id_pc4   = ifidOut.pc4;
   assign id_valid = ifidOut.valid;

`ifdef IF_PERF_CNT_EN
   word_t fetchCnt_q;
   word_t stallCnt_q;
   word_t flushCnt_q;

   // Event counters: a fetch is a cycle where IF/ID loads a real instruction,
   // a stall only counts when no redirect overrides it, and every redirect
   // cycle is a flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetchCnt_q <= '0;
         stallCnt_q <= '0;
         flushCnt_q <= '0;
      end else begin
         if (redirect) begin
            flushCnt_q <= flushCnt_q + 32'd1;
         end else if (stall) begin
            stallCnt_q <= stallCnt_q + 32'd1;
         end else begin
            fetchCnt_q <= fetchCnt_q + 32'd1;
         end
      end
   end

   assign perf_fetch = fetchCnt_q;
   assign perf_stall = stallCnt_q;
   assign perf_flush = flushCnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage
// Self-checking bench for if_stage. A small instruction memory answers
// imem_addr combinationally; a rule-level model of the fetch stage tracks what
// the PC and IF/ID contents must be, and a negedge process compares the DUT
// against it every cycle. Directed sequences pin known literal values, then
// random stall/redirect traffic and a mid-run reset pulse follow.
// -----------------------------------------------------------------------------
module tb_if_stage;

   localparam logic [31:0] LW_T0 = 32'h8C08_0000;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        redirect;
   logic [31:0] redirectPc;
   logic [31:0] imemAddr;
   logic [31:0] imemInstr;
   logic [31:0] idInstr;
   logic [31:0] idPc;
   logic [31:0] idPc4;
   logic        idValid;
`ifdef IF_PERF_CNT_EN
   logic [31:0] perfFetch;
   logic [31:0] perfStall;
   logic [31:0] perfFlush;
`endif

   logic [31:0] mem [64];

   // Reference state: where the PC must be and what ID must see.
   logic [31:0] mPc;
   logic [31:0] mInstr;
   logic [31:0] mIdPc;
   logic [31:0] mIdPc4;
   logic        mValid;
   int unsigned mFetch;
   int unsigned mStall;
   int unsigned mFlush;

   int  checks;
   int  failures;
   bit  compareOn;

   if_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirectPc),
      .imem_addr   (imemAddr),
      .imem_instr  (imemInstr),
      .id_instr    (idInstr),
      .id_pc       (idPc),
      .id_pc4      (idPc4),
      .id_valid    (idValid)
`ifdef IF_PERF_CNT_EN
      ,
      .perf_fetch  (perfFetch),
      .perf_stall  (perfStall),
      .perf_flush  (perfFlush)
`endif
   );

   // Memory decodes only its own index bits.
   assign imemInstr = mem[imemAddr[7:2]];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic modelReset();
      mPc    = 32'h0;
      mInstr = 32'h0;
      mIdPc  = 32'h0;
      mIdPc4 = 32'h0;
      mValid = 1'b0;
      mFetch = 0;
      mStall = 0;
      mFlush = 0;
   endtask

   // Drive one cycle of inputs, let the edge happen, then advance the model by
   // the stage's rules for that cycle.
   task automatic applyStimulus(input bit st, input bit rd, input logic [31:0] rpc);
      stall      = st;
      redirect   = rd;
      redirectPc = rpc;
      @(posedge clk);
      #1;
      if (rd) begin
         mPc    = {rpc[31:2], 2'b00};
         mInstr = 32'h0;
         mValid = 1'b0;
         mFlush++;
      end else if (st) begin
         mStall++;
      end else begin
         mInstr = mem[mPc[7:2]];
         mIdPc  = mPc;
         mIdPc4 = mPc + 32'd4;
         mValid = 1'b1;
         mPc    = mPc + 32'd4;
         mFetch++;
      end
   endtask

   // Continuous comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (compareOn) begin
         checkOutput("cmp_imem_addr", imemAddr, mPc);
         checkOutput("cmp_id_instr", idInstr, mInstr);
         checkOutput("cmp_id_pc", idPc, mIdPc);
         checkOutput("cmp_id_pc4", idPc4, mIdPc4);
         checkOutput("cmp_id_valid", {31'b0, idValid}, {31'b0, mValid});
         checkOutput("cmp_pc_align", {30'b0, imemAddr[1:0]}, 32'h0);
`ifdef IF_PERF_CNT_EN
         checkOutput("cmp_perf_fetch", perfFetch, mFetch);
         checkOutput("cmp_perf_stall", perfStall, mStall);
         checkOutput("cmp_perf_flush", perfFlush, mFlush);
`endif
      end
   end

   initial begin
      int  guard;
      bit  rndStall;
      bit  rndRedirect;

      checks    = 0;
      failures  = 0;
      compareOn = 1'b0;
      mem[0]    = LW_T0;
      for (int i = 1; i < 64; i++) mem[i] = $urandom;
      modelReset();

      rst_n      = 1'b0;
      stall      = 1'b0;
      redirect   = 1'b0;
      redirectPc = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_imem_addr", imemAddr, 32'h0);
      checkOutput("reset_id_instr", idInstr, 32'h0);
      checkOutput("reset_id_pc", idPc, 32'h0);
      checkOutput("reset_id_pc4", idPc4, 32'h0);
      checkOutput("reset_id_valid", {31'b0, idValid}, 32'h0);
      rst_n     = 1'b1;
      compareOn = 1'b1;

      // First fetch after release captures word 0.
      applyStimulus(0, 0, 32'h0);
      checkOutput("first_id_instr", idInstr, LW_T0);
      checkOutput("first_id_pc", idPc, 32'h0);
      checkOutput("first_id_pc4", idPc4, 32'h4);
      checkOutput("first_id_valid", {31'b0, idValid}, 32'h1);
      checkOutput("first_imem_addr", imemAddr, 32'h4);

      applyStimulus(0, 0, 32'h0);
      checkOutput("pre_stall_addr", imemAddr, 32'h8);

      // Two stalled cycles freeze everything.
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1, 0, 32'h0);
         checkOutput("stall_imem_addr", imemAddr, 32'h8);
         checkOutput("stall_id_pc", idPc, 32'h4);
         checkOutput("stall_id_instr", idInstr, mem[1]);
      end
      applyStimulus(0, 0, 32'h0);
      checkOutput("post_stall_id_pc", idPc, 32'h8);

      // Walk forward to 0x28 and redirect to 0x2C.
      guard = 0;
      while (imemAddr != 32'h28 && guard < 32) begin
         applyStimulus(0, 0, 32'h0);
         guard++;
      end
      checkOutput("reach_0x28", imemAddr, 32'h28);
      applyStimulus(0, 1, 32'h0000_002C);
      checkOutput("redir_imem_addr", imemAddr, 32'h2C);
      checkOutput("redir_id_valid", {31'b0, idValid}, 32'h0);
      checkOutput("redir_id_instr", idInstr, 32'h0);
      applyStimulus(0, 0, 32'h0);
      checkOutput("after_redir_id_pc", idPc, 32'h2C);
      checkOutput("after_redir_id_valid", {31'b0, idValid}, 32'h1);

      // Redirect beats stall and the target is aligned.
      applyStimulus(1, 1, 32'h0000_0031);
      checkOutput("redir_stall_addr", imemAddr, 32'h30);
      checkOutput("redir_stall_valid", {31'b0, idValid}, 32'h0);

      // Wrap at the top of the address space.
      applyStimulus(0, 1, 32'hFFFF_FFFC);
      checkOutput("wrap_set_addr", imemAddr, 32'hFFFF_FFFC);
      applyStimulus(0, 0, 32'h0);
      checkOutput("wrap_id_pc", idPc, 32'hFFFF_FFFC);
      checkOutput("wrap_id_pc4", idPc4, 32'h0);
      checkOutput("wrap_imem_addr", imemAddr, 32'h0);

      // Random traffic.
      for (int i = 0; i < 300; i++) begin
         rndStall    = ($urandom_range(0, 3) == 0);
         rndRedirect = ($urandom_range(0, 6) == 0);
         applyStimulus(rndStall, rndRedirect, $urandom);
      end

      // Short reset pulse with a stall and redirect pending.
      stall      = 1'b1;
      redirect   = 1'b1;
      redirectPc = 32'h0000_0100;
      #1;
      rst_n = 1'b0;
      modelReset();
      #1;
      checkOutput("pulse_imem_addr", imemAddr, 32'h0);
      checkOutput("pulse_id_instr", idInstr, 32'h0);
      checkOutput("pulse_id_pc", idPc, 32'h0);
      checkOutput("pulse_id_pc4", idPc4, 32'h0);
      checkOutput("pulse_id_valid", {31'b0, idValid}, 32'h0);
`ifdef IF_PERF_CNT_EN
      checkOutput("pulse_perf_fetch", perfFetch, 32'h0);
      checkOutput("pulse_perf_stall", perfStall, 32'h0);
      checkOutput("pulse_perf_flush", perfFlush, 32'h0);
`endif
      stall    = 1'b0;
      redirect = 1'b0;
      #4;
      rst_n = 1'b1;
      applyStimulus(0, 0, 32'h0);
      checkOutput("resume_id_pc", idPc, 32'h0);
      checkOutput("resume_id_instr", idInstr, LW_T0);
      checkOutput("resume_imem_addr", imemAddr, 32'h4);

      for (int i = 0; i < 100; i++) begin
         rndStall    = ($urandom_range(0, 3) == 0);
         rndRedirect = ($urandom_range(0, 6) == 0);
         applyStimulus(rndStall, rndRedirect, $urandom);
      end

      @(negedge clk);
      compareOn = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000, instruction word inserted on a bubble.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 stall  input  1  hazard-unit hold, e.g. load-use: freeze PC and IF/ID.
REQ-006 redirect  input  1  taken branch/jump resolved in ID.
REQ-007 redirect_pc  input  32  redirect target.
REQ-008 imem_addr  output  32  fetch address to instruction memory; combinational from PC.
REQ-009 imem_instr  input  32  instruction word returned combinationally for imem_addr.
REQ-010 id_instr  output  32  registered IF/ID instruction.
REQ-011 id_pc  output  32  registered PC of id_instr.
REQ-012 id_pc4  output  32  registered id_pc+4.
REQ-013 id_valid  output  1  IF/ID holds a real instruction; 0 means bubble.

Function
REQ-014 imem_addr SHALL equal the PC register every cycle; zero-latency memory; IF/ID captures one cycle after the address is presented.
REQ-015 Normal cycle (no stall, no redirect): PC<=PC+4; id_instr<=imem_instr; id_pc<=PC; id_pc4<=PC+4; id_valid<=1.
REQ-016 stall=1, redirect=0: PC and all id_* outputs SHALL hold their values.
REQ-017 redirect=1, whether stall is 0 or 1: PC<=redirect_pc with bits[1:0] forced to 0; id_instr<=NOP_INSTR; id_valid<=0; id_pc and id_pc4 hold. The wrong-path instruction is flushed; redirect has priority over stall.
REQ-018 PC+4 SHALL wrap modulo 2^32: PC 32'hFFFF_FFFC goes to 32'h0000_0000, and id_pc4 wraps likewise.
REQ-019 PC bits[1:0] SHALL always be 0.
REQ-020 Behaviour SHALL NOT depend on imem depth: the memory decodes its own index bits.
REQ-021 After a bubble, the next non-stalled, non-redirect cycle SHALL fetch normally from the new PC.

Reset
REQ-022 While rst_n=0: PC=RESET_PC, id_instr=NOP_INSTR, id_pc=0, id_pc4=0, id_valid=0, all counters=0. Reset is asynchronous and overrides all inputs.
REQ-023 Reset asserted mid-operation SHALL discard any pending redirect or stall.
REQ-024 On the first edge after release, IF/ID SHALL capture the instruction at RESET_PC.

Configuration
REQ-025 With macro IF_PERF_CNT_EN defined, the block SHALL add three 32-bit outputs:
- perf_fetch: counts cycles with id_valid loaded as 1.
- perf_stall: counts stall=1 && redirect=0 cycles.
- perf_flush: counts redirect=1 cycles.
REQ-026 Counters SHALL wrap at 2^32 and be cleared by rst_n.
REQ-027 Without IF_PERF_CNT_EN, these ports and registers SHALL NOT exist; function is otherwise identical.

Structure
REQ-028 The shared package (cpu_pkg) SHALL hold:
- typedef word_t (32-bit).
- typedef if_id_t, a struct of instr, pc, pc4, valid.
- constants NOP_INSTR and RESET_PC defaults.
REQ-029 Sub-module if_id_reg SHALL hold the IF/ID pipeline register with hold/flush controls. if_stage SHALL own the PC register and next-PC mux.

Verification
REQ-030 Reset and release, imem loaded with lw $t0,0($zero)=32'h8C08_0000 at word 0 -> cycle 1: id_instr=32'h8C08_0000, id_pc=0, id_pc4=4, id_valid=1; imem_addr=4.
REQ-031 stall=1 for 2 cycles while imem_addr=8 -> imem_addr stays 8 and id_* unchanged for 2 cycles; on release id_pc=8.
REQ-032 redirect=1, redirect_pc=32'h0000_002C while imem_addr=32'h28 -> next cycle: imem_addr=32'h2C, id_valid=0, id_instr=0; following cycle: id_pc=32'h2C, id_valid=1.
REQ-033 stall=1 and redirect=1 together, redirect_pc=32'h0000_0031 -> imem_addr=32'h30, id_valid=0.
REQ-034 PC forced to 32'hFFFF_FFFC via redirect -> next fetch: id_pc4=0, imem_addr=0.
REQ-035 rst_n pulsed low for half a cycle mid-run with IF_PERF_CNT_EN defined -> all outputs immediately at reset values; perf_fetch, perf_stall and perf_flush=0; fetch resumes from RESET_PC.
